// File: rtl/conv2d_stream_if.sv
// Stream bundle for conv2d_stream: pixel in, result out, kernel write port.
// master = pixel source / result sink side, slave = convolution engine.
interface conv2d_stream_if #(
  parameter int WORD_SIZE  = 8,
  parameter int COEF_WIDTH = 8,
  parameter int KERNEL_DIM = 3
);
  localparam int AW = $clog2(KERNEL_DIM * KERNEL_DIM);

  // Both streams use valid/ready: a word moves on a rising clk edge where
  // valid && ready are both high; valid and its data hold until that edge,
  // and ready may depend combinationally on the receiver's state.
  logic                         in_valid;
  logic                         in_ready;
  logic [WORD_SIZE-1:0]         in_pixel;
  logic                         out_valid;
  logic                         out_ready;
  logic [WORD_SIZE-1:0]         out_pixel;
  logic                         out_last;
  logic                         coef_we;
  logic [AW-1:0]                coef_addr;
  logic signed [COEF_WIDTH-1:0] coef_data;

  modport master (
    output in_valid, in_pixel, out_ready, coef_we, coef_addr, coef_data,
    input  in_ready, out_valid, out_pixel, out_last
  );

  modport slave (
    input  in_valid, in_pixel, out_ready, coef_we, coef_addr, coef_data,
    output in_ready, out_valid, out_pixel, out_last
  );
endinterface

// File: rtl/conv2d_stream.sv
// Streaming KxK "valid"-window 2-D convolution: line buffers, shadow/active kernel,
// 4-stage pipeline (window, multiply, sum, shift/clamp). Option macro: CONV_ABS_EN.
module conv2d_stream #(
  parameter int WORD_SIZE  = 8,
  parameter int ROW_SIZE   = 540,
  parameter int NUM_ROWS   = 540,
  parameter int KERNEL_DIM = 3,
  parameter int COEF_WIDTH = 8,
  parameter int SHIFT      = 0
) (
  input logic            clk,
  input logic            rst,
  conv2d_stream_if.slave bus
);
  localparam int K  = KERNEL_DIM;
  localparam int KK = K * K;
  localparam int CW = $clog2(ROW_SIZE);
  localparam int RW = $clog2(NUM_ROWS);
  localparam int PW = WORD_SIZE + COEF_WIDTH + 1;
  localparam int SW = PW + $clog2(KK);

  localparam logic [CW-1:0]        COL_LAST = CW'(ROW_SIZE - 1);
  localparam logic [RW-1:0]        ROW_LAST = RW'(NUM_ROWS - 1);
  localparam logic [CW-1:0]        COL_MIN  = CW'(K - 1);
  localparam logic [RW-1:0]        ROW_MIN  = RW'(K - 1);
  localparam logic signed [SW-1:0] PIX_MAX  = SW'((1 << WORD_SIZE) - 1);

  typedef logic signed [COEF_WIDTH-1:0] coef_t;
  typedef logic [WORD_SIZE-1:0]         pix_t;

  function automatic coef_t default_coef(input int idx);
    return (idx == KK / 2) ? coef_t'(KK - 1) : coef_t'(-1);
  endfunction

  logic en;
  logic accept;

  assign en          = !bus.out_valid || bus.out_ready;
  assign accept      = bus.in_valid && en;
  assign bus.in_ready = en;

  // ---------------------------------------------------------------- position
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          frame_start;
  logic          win_ok;
  logic          at_last;

  assign frame_start = (row == '0) && (col == '0);
  assign win_ok      = (row >= ROW_MIN) && (col >= COL_MIN);
  assign at_last     = (row == ROW_LAST) && (col == COL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // ------------------------------------------------- S1: line buffers/window
  // lb[0] holds the previous row, lb[K-2] the oldest; never cleared, since
  // win_ok masks every window that could see stale rows.
  pix_t lb      [K-1][ROW_SIZE];
  pix_t col_vec [K];
  pix_t win     [K][K];

  always_comb begin
    col_vec[K-1] = bus.in_pixel;
    for (int m = 1; m < K; m++) begin
      col_vec[K-1-m] = lb[m-1][col];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb[0][col] <= bus.in_pixel;
      for (int m = 1; m < K - 1; m++) begin
        lb[m][col] <= lb[m-1][col];
      end
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) begin
          win[i][j] <= win[i][j+1];
        end
        win[i][K-1] <= col_vec[i];
      end
    end
  end

  // ------------------------------------------------------------ kernel store
  // The active copy reads the shadow's pre-edge value, so a write landing on
  // the (0,0) accept edge only reaches the following frame.
  coef_t shadow_k [KK];
  coef_t active_k [KK];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < KK; n++) begin
        shadow_k[n] <= default_coef(n);
        active_k[n] <= default_coef(n);
      end
    end else begin
      if (bus.coef_we && (int'(bus.coef_addr) < KK)) begin
        shadow_k[bus.coef_addr] <= bus.coef_data;
      end
      if (accept && frame_start) begin
        for (int n = 0; n < KK; n++) begin
          active_k[n] <= shadow_k[n];
        end
      end
    end
  end

  // -------------------------------------------------- stage valid/last bits
  logic s1_valid, s1_last;
  logic s2_valid, s2_last;
  logic s3_valid, s3_last;
  logic out_valid_q, out_last_q;
  pix_t out_pixel_q;
  pix_t clamped;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_last     <= 1'b0;
      s2_valid    <= 1'b0;
      s2_last     <= 1'b0;
      s3_valid    <= 1'b0;
      s3_last     <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_pixel_q <= '0;
    end else if (en) begin
      s1_valid    <= accept && win_ok;
      s1_last     <= accept && at_last;
      s2_valid    <= s1_valid;
      s2_last     <= s1_last;
      s3_valid    <= s2_valid;
      s3_last     <= s2_last;
      out_valid_q <= s3_valid;
      out_last_q  <= s3_valid && s3_last;
      out_pixel_q <= clamped;
    end
  end

  // --------------------------------------------------------- S2: multiply
  logic signed [PW-1:0] prod [KK];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          prod[i*K+j] <= PW'($signed({1'b0, win[i][j]})) * PW'(active_k[i*K+j]);
        end
      end
    end
  end

  // -------------------------------------------------------------- S3: sum
  logic signed [SW-1:0] sum_comb;
  logic signed [SW-1:0] s3_sum;

  always_comb begin
    sum_comb = '0;
    for (int n = 0; n < KK; n++) begin
      sum_comb = sum_comb + SW'(prod[n]);
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      s3_sum <= sum_comb;
    end
  end

  // ----------------------------------------------------- S4: shift / clamp
  logic signed [SW-1:0] shifted;
  logic signed [SW-1:0] mag;

  always_comb begin
    shifted = s3_sum >>> SHIFT;
`ifdef CONV_ABS_EN
    mag = shifted[SW-1] ? -shifted : shifted;
`else
    mag = shifted;
`endif
    if (mag[SW-1]) begin
      clamped = '0;
    end else if (mag > PIX_MAX) begin
      clamped = '1;
    end else begin
      clamped = mag[WORD_SIZE-1:0];
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_pixel = out_pixel_q;

endmodule

// File: doc/conv2d_stream.md
# conv2d_stream

Streaming K×K 2-D convolution engine with valid/ready handshakes, runtime-loadable signed kernel, frame-aware row/column tracking and configurable output scaling. It generalises the fixed 3×3 Laplacian filter to arbitrary kernel size, pixel width and coefficient width. It sits in the CNN image pipeline between the pixel source and downstream feature stages. It emits only fully-valid ("valid"-mode) windows per frame, with full backpressure support.

## Interface
- WORD_SIZE, 8, pixel width (unsigned in and out)
- ROW_SIZE, 540, pixels per row
- NUM_ROWS, 540, rows per frame
- KERNEL_DIM, 3, kernel side K; odd, 3..7
- COEF_WIDTH, 8, signed coefficient width
- SHIFT, 0, arithmetic right shift applied to the sum before clamping
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high; clock clk
- in_valid  in  1  input pixel valid
- in_ready  out  1  input accepted when in_valid && in_ready
- in_pixel  in  WORD_SIZE  raster-order pixel
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_pixel  out  WORD_SIZE  clamped result
- out_last  out  1  high with the final result of a frame
- coef_we  in  1  shadow-kernel write strobe
- coef_addr  in  $clog2(K*K)  index i*K+j; i=0 is the oldest row, j=0 the oldest column
- coef_data  in  COEF_WIDTH  signed coefficient

## Operation
- Stall enable: en = !out_valid || out_ready. in_ready = en, driven combinationally. All pipeline stages advance only when en=1.
- Counters col (0..ROW_SIZE-1) and row (0..NUM_ROWS-1) give the position of each accepted pixel.
  - col advances on every accept.
  - On col wrap, row advances.
  - After (NUM_ROWS-1, ROW_SIZE-1) both counters wrap to 0.
- Storage: K-1 line buffers of ROW_SIZE words plus a K×K window shift register, all updated on accept.
  - Line buffers are never cleared.
  - Stale data is masked by the validity rule below.
- Window validity: a window is valid when the accepted pixel has row ≥ K-1 and col ≥ K-1. This suppresses row-wrap windows.
  - Output frame size is (NUM_ROWS-K+1)×(ROW_SIZE-K+1).
- Kernel storage:
  - coef_we writes the shadow kernel.
  - The active kernel copies the shadow kernel on the edge that accepts pixel (0,0).
  - Mid-frame writes therefore take effect at the next frame.
  - If coef_we coincides with the (0,0) accept, the active copy takes the pre-write shadow value.
- Default kernel, loaded into both active and shadow at reset: centre = K*K-1, all others = -1 (Laplacian).
- Arithmetic:
  - Pixel is zero-extended to signed.
  - Product width is WORD_SIZE+COEF_WIDTH+1.
  - Sum width is product width + $clog2(K*K). No overflow is possible.
  - Sum is shifted arithmetically right by SHIFT (rounds toward −inf).
  - Result is clamped to [0, 2^WORD_SIZE-1].
- out_last is set for the window whose accepted pixel is (NUM_ROWS-1, ROW_SIZE-1).

## Timing
- Pipeline stages: S1 window/line-buffer update (accept edge t), S2 multiply (t+1), S3 adder tree (t+2), S4 shift/clamp/output register (t+3).
- Latency: out_valid, out_pixel and out_last are valid after edge t+3 when there are no stalls.
- Throughput: 1 pixel/clock.
- Stalls: each stall cycle adds one cycle of latency. No data is lost or duplicated.
- Holding rule: while out_valid && !out_ready, out_pixel and out_last hold their values and in_ready=0.
- Invalid windows propagate as bubbles; out_valid=0 for them.
- Reset values: out_valid=0, out_pixel=0, out_last=0, in_ready=1, row=col=0, all stage valid bits 0, both kernels = default.
- Reset mid-frame:
  - All in-flight results are discarded; out_valid=0 after the reset edge.
  - The next accepted pixel is treated as (0,0).
  - Coefficients written before reset are lost.

## Configuration
- CONV_ABS_EN defined: S4 takes |shifted sum| before the upper clamp, so negative responses give edge magnitude.
- CONV_ABS_EN undefined: negative results clamp to 0.
- Latency is identical in both builds.

## Test plan
- Bench parameters: ROW_SIZE=8, NUM_ROWS=6, K=3, default kernel.
- Constant frame of 100 -> 24 outputs, all 0; out_last only on the 24th.
- Impulse 255 at (2,3), all other pixels 0:
  - Window centred on the impulse -> 255 (2040 clamped).
  - Its 8 neighbours -> 0, or 255 with CONV_ABS_EN.
  - All other outputs -> 0.
- Ramp pixel = col*10 over two frames, zero-sum kernel -> no out_valid while col<2; exactly 24 results per frame; all results 0 (interior linear ramp).
- Random out_ready (50% duty) and in_valid gaps over 3 frames -> output stream bit-identical to the no-stall run; in_ready=0 exactly when out_valid && !out_ready.
- SHIFT=3, write all nine coefs=1 mid-frame, constant input 80 -> current frame unchanged (0s); next frame all outputs 90 (720>>3).
- Assert rst after 20 accepted pixels -> out_valid=0 next cycle; following frame yields exactly 24 results, with out_last on the 24th.
